// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter.
package i2s_pkg;

    localparam int FRAME_PERIODS = 64;
    localparam int SLOT_PERIODS  = 32;
    // Widest sample the frame layout can carry (one slot minus the delay bit).
    localparam int MAX_DATA_W    = 31;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Samples are stored at the widest legal width; only the low DATA_W bits are sent.
    typedef struct packed {
        logic signed [MAX_DATA_W-1:0] lft;
        logic signed [MAX_DATA_W-1:0] rght;
    } stereo_smpl_t;

    // Serial bit carried in bit period 'per' of a frame (standard one-bit-delayed I2S).
    function automatic logic slot_bit(input stereo_smpl_t s, input logic [5:0] per,
                                      input int data_w);
        int         p;
        logic [4:0] idx;
        logic       b;
        p   = int'(per);
        idx = 5'd0;
        b   = 1'b0;
        if ((p >= 32'sd1) && (p <= data_w)) begin
            idx = 5'(data_w - p);
            b   = s.lft[idx];
        end else if ((p >= SLOT_PERIODS + 32'sd1) && (p <= SLOT_PERIODS + data_w)) begin
            idx = 5'(data_w + SLOT_PERIODS - p);
            b   = s.rght[idx];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/i2s_tx_sclk_gen.sv
// Bit-clock generator: divides clk into bit periods and counts periods in a frame.
module i2s_tx_sclk_gen
    import i2s_pkg::*;
#(
    parameter int SCLK_HALF = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    output logic       o_sclk,
    output logic [5:0] o_per_cnt,
    output logic       o_per_end,
    output logic       o_frm_end
);

    localparam int DIV_W = $clog2(2 * SCLK_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_HALF);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [5:0]       r_per_cnt;
    logic             r_sclk;

    assign o_per_end = i_run && (r_div_cnt == DIV_LAST);
    assign o_frm_end = o_per_end && (r_per_cnt == 6'(FRAME_PERIODS - 1));
    assign o_sclk    = r_sclk;
    assign o_per_cnt = r_per_cnt;

    // Next divider value: free-running while running, parked at zero otherwise.
    always_comb begin
        w_div_nxt = '0;
        if (i_run) begin
            if (r_div_cnt == DIV_LAST) begin
                w_div_nxt = '0;
            end else begin
                w_div_nxt = r_div_cnt + DIV_W'(1);
            end
        end else begin
            w_div_nxt = '0;
        end
    end

    // Divider, period counter and registered bit clock (high in the second half-period).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_per_cnt <= 6'd0;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_sclk    <= (w_div_nxt >= DIV_HALF);
            if (!i_run) begin
                r_per_cnt <= 6'd0;
            end else if (o_per_end) begin
                r_per_cnt <= r_per_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S bus-master transmitter with a double-buffered stereo sample input.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int SCLK_HALF = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] lft_smpl,
    input  logic [DATA_W-1:0] rght_smpl,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data,
    output logic              frm_strt,
    output logic              underrun
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_start;
    logic         w_run;
    logic         w_per_end;
    logic         w_frm_end;
    logic [5:0]   w_per_cnt;
    logic [5:0]   w_per_nxt;
    logic         w_acc;
    stereo_smpl_t r_hold;
    stereo_smpl_t r_shadow;
    logic         r_full;
    logic         r_frm_strt;
    logic         r_underrun;
    logic         r_ws;
    logic         r_data;
    logic         w_ws_nxt;
    logic         w_data_nxt;

    assign w_run     = (r_state == RUN);
    assign w_acc     = smpl_vld && !r_full;
    assign w_per_nxt = w_per_cnt + 6'd1;

    assign smpl_rdy = ~r_full;
    assign I2S_ws   = r_ws;
    assign I2S_data = r_data;
    assign frm_strt = r_frm_strt;
    assign underrun = r_underrun;

    i2s_tx_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_run),
        .o_sclk    (I2S_sclk),
        .o_per_cnt (w_per_cnt),
        .o_per_end (w_per_end),
        .o_frm_end (w_frm_end)
    );

    // Run/idle decision; en only matters when idle or at a frame boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_frm_end) begin
                    if (en) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame-start and underrun pulses, aligned with the first cycle of period 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_strt <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_frm_strt <= w_start;
            r_underrun <= w_start && !(r_full || w_acc);
        end
    end

    // Double buffer: holding takes new pairs, shadow is swapped in during the frm_strt cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= '0;
            r_shadow <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_hold <= '{lft: MAX_DATA_W'(lft_smpl), rght: MAX_DATA_W'(rght_smpl)};
            end
            if (r_frm_strt) begin
                r_shadow <= r_full ? r_hold : '0;
                r_full   <= w_acc;
            end else if (w_acc) begin
                r_full <= 1'b1;
            end
        end
    end

    // Word select and data for the period about to begin, updated on the sclk falling edge.
    always_comb begin
        w_ws_nxt   = r_ws;
        w_data_nxt = r_data;
        if (w_per_end) begin
            w_ws_nxt   = (w_per_nxt >= 6'(SLOT_PERIODS));
            w_data_nxt = slot_bit(r_shadow, w_per_nxt, DATA_W);
        end else begin
            w_ws_nxt   = r_ws;
            w_data_nxt = r_data;
        end
    end

    // Serial output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ws   <= 1'b0;
            r_data <= 1'b0;
        end else begin
            r_ws   <= w_ws_nxt;
            r_data <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: frame-level expectations from a buffer model, checked by a serial decoder.
module tb_i2s_tx;

    localparam int DW       = 24;
    localparam int SH       = 4;
    localparam int PER_CLKS = 2 * SH;
    localparam int FRM_CLKS = 64 * PER_CLKS;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          vld;
    logic [DW-1:0] lft;
    logic [DW-1:0] rght;
    logic          smpl_rdy, I2S_sclk, I2S_ws, I2S_data, frm_strt, underrun;

    i2s_tx #(.DATA_W(DW), .SCLK_HALF(SH)) dut (
        .clk(clk), .rst(rst), .en(en), .lft_smpl(lft), .rght_smpl(rght),
        .smpl_vld(vld), .smpl_rdy(smpl_rdy), .I2S_sclk(I2S_sclk), .I2S_ws(I2S_ws),
        .I2S_data(I2S_data), .frm_strt(frm_strt), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;
    frame_t exp_q[$];

    // Reference model: position within the frame as a plain integer, holding as a flag + pair.
    bit            m_run  = 1'b0;
    int            m_pos  = 0;
    bit            m_full = 1'b0;
    logic [DW-1:0] m_hl, m_hr;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Cycle-level expectations for handshake, pulses and bit clock; queues each frame's content.
    always @(negedge clk) begin
        bit     exp_frm;
        bit     exp_sclk;
        bit     acc;
        frame_t f;
        exp_frm  = m_run && (m_pos == 0);
        exp_sclk = m_run && ((m_pos % PER_CLKS) >= SH);
        chk("frm_strt", 64'(frm_strt), 64'(exp_frm));
        chk("underrun", 64'(underrun), 64'(exp_frm && !m_full));
        chk("smpl_rdy", 64'(smpl_rdy), 64'(!m_full));
        chk("sclk", 64'(I2S_sclk), 64'(exp_sclk));
        if (!m_run) begin
            chk("idle_ws", 64'(I2S_ws), 64'd0);
            chk("idle_data", 64'(I2S_data), 64'd0);
        end
        if (exp_frm) begin
            f.l = m_full ? m_hl : '0;
            f.r = m_full ? m_hr : '0;
            exp_q.push_back(f);
        end
        if (rst) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_full = 1'b0;
            exp_q.delete();
        end else begin
            acc = vld && !m_full;
            if (exp_frm) m_full = acc;
            else if (acc) m_full = 1'b1;
            if (acc) begin
                m_hl = lft;
                m_hr = rght;
            end
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end else if (m_pos == FRM_CLKS - 1) begin
                m_pos = 0;
                m_run = en;
            end else begin
                m_pos++;
            end
        end
    end

    // Monitor: decodes frames from the serial lines at sclk rising edges and pops the scoreboard.
    bit          prev_sclk = 1'b0;
    bit          prev_data = 1'b0;
    bit          d_active  = 1'b0;
    int          d_idx     = 0;
    int          cyc       = 0;
    int          last_rise = 0;
    logic [63:0] d_bits, d_ws;
    always @(negedge clk) begin
        frame_t        f;
        logic [DW-1:0] gl, gr;
        logic [63:0]   zmask, wexp;
        if (rst) begin
            d_active = 1'b0;
            d_idx    = 0;
        end else if (I2S_sclk && !prev_sclk) begin
            chk("data_stable_on_rise", 64'(I2S_data), 64'(prev_data));
            if (d_active) chk("sclk_period", 64'(cyc - last_rise), 64'(PER_CLKS));
            if (!d_active) begin
                d_active = 1'b1;
                d_idx    = 0;
            end
            d_bits[d_idx] = I2S_data;
            d_ws[d_idx]   = I2S_ws;
            d_idx++;
            last_rise = cyc;
            if (d_idx == 64) begin
                d_active = 1'b0;
                zmask    = '1;
                wexp     = '0;
                for (int i = 0; i < DW; i++) begin
                    gl[DW-1-i] = d_bits[1+i];
                    gr[DW-1-i] = d_bits[33+i];
                    zmask[1+i]  = 1'b0;
                    zmask[33+i] = 1'b0;
                end
                for (int i = 32; i < 64; i++) wexp[i] = 1'b1;
                chk("ws_pattern", d_ws, wexp);
                chk("pad_bits_zero", d_bits & zmask, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    f = exp_q.pop_front();
                    chk("left", 64'(gl), 64'(f.l));
                    chk("right", 64'(gr), 64'(f.r));
                end
            end
        end
        prev_sclk = I2S_sclk;
        prev_data = I2S_data;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair and wait for it to be taken; optionally keep vld high afterwards.
    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit keep);
        int n;
        n    = 0;
        vld  = 1'b1;
        lft  = l;
        rght = r;
        do begin
            @(negedge clk);
            n++;
        end while (!smpl_rdy && n < 4 * FRM_CLKS);
        if (!smpl_rdy) chk("send_timeout", 64'd1, 64'd0);
        tick();
        if (!keep) vld = 1'b0;
    endtask

    // Return #1 into the next cycle whose frame position is 'target'.
    task automatic wait_pos(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(m_run && m_pos == target) && n < 4 * FRM_CLKS);
        if (!(m_run && m_pos == target)) chk("wait_pos_timeout", 64'd1, 64'd0);
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        vld  = 1'b0;
        lft  = '0;
        rght = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Known pattern fed after the first frm_strt: frame 1 underruns, frame 2 carries it.
        en = 1'b1;
        wait_pos(0);
        repeat (3) tick();
        send(24'hA5A5A5, 24'h5A5A5A, 1'b0);

        // Streaming with vld held high.
        for (int k = 0; k < 8; k++) send(DW'($urandom()), DW'($urandom()), 1'b1);
        vld = 1'b0;

        // Three pairs, then starve for a frame, then resume.
        for (int k = 0; k < 3; k++) send(DW'($urandom()), DW'($urandom()), 1'b1);
        vld = 1'b0;
        wait_pos(0);
        wait_pos(0);
        for (int k = 0; k < 3; k++) send(DW'($urandom()), DW'($urandom()), 1'b1);
        vld = 1'b0;

        // Disable mid-frame at period 40: frame completes, then idle.
        send(DW'($urandom()), DW'($urandom()), 1'b0);
        wait_pos(40 * PER_CLKS);
        en = 1'b0;
        repeat (FRM_CLKS + 20) tick();

        // Reset at period 20 with holding full; old pair must not reappear.
        en = 1'b1;
        wait_pos(0);
        repeat (4) tick();
        send(DW'($urandom()), DW'($urandom()), 1'b0);
        wait_pos(20 * PER_CLKS);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_pos(0);

        // vld arrives exactly on the frm_strt cycle while holding is full.
        repeat (5) tick();
        send(DW'($urandom()), DW'($urandom()), 1'b0);
        wait_pos(0);
        send(DW'($urandom()), DW'($urandom()), 1'b0);
        wait_pos(0);
        wait_pos(0);
        en = 1'b0;
        repeat (FRM_CLKS + 20) tick();

        chk("pending_frames", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
